// File: rtl/wam_dis_pkg.sv
// rtl/wam_dis_pkg.sv - shared encodings and helpers for the tube display scheduler
package wam_dis_pkg;

  // Source code reported on src
  localparam logic [1:0] SRC_SCORE  = 2'd0;
  localparam logic [1:0] SRC_TIMER  = 2'd1;
  localparam logic [1:0] SRC_BANNER = 2'd2;

  // Scheduler state; values line up with the src encodings
  typedef enum logic [1:0] {
    ST_SCORE  = 2'd0,
    ST_TIMER  = 2'd1,
    ST_BANNER = 2'd2
  } state_t;

  // Tube nibble codes
  localparam logic [3:0]  NIB_BLANK  = 4'hA;
  localparam logic [3:0]  NIB_HIO    = 4'hB;
  localparam logic [15:0] WORD_BLANK = 16'hAAAA;

  // Score word with the HIO prefix; lzb blanks leading zero digits (ones digit always shown)
  function automatic logic [15:0] score_word(input logic [11:0] s, input logic lzb);
    logic [3:0] d2;
    logic [3:0] d1;
    d2 = s[11:8];
    d1 = s[7:4];
    if (lzb && (s[11:8] == 4'd0)) begin
      d2 = NIB_BLANK;
      if (s[7:4] == 4'd0) d1 = NIB_BLANK;
    end
    return {NIB_HIO, d2, d1, s[3:0]};
  endfunction

endpackage

// File: rtl/wam_dis_blink.sv
// rtl/wam_dis_blink.sv - banner duration counter and blink phase generator
module wam_dis_blink
  import wam_dis_pkg::*;
#(
  parameter int BLINK_CYC  = 8,
  parameter int BANNER_CYC = 64
) (
  input  logic clk_16,
  input  logic rst_n,
  input  logic restart,
  input  logic enable,
  output logic phase,
  output logic done
);

  localparam int BW = $clog2(BLINK_CYC + 1);
  localparam int DW = $clog2(BANNER_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);
  localparam logic [DW-1:0] DUR_LAST   = DW'(BANNER_CYC - 1);

  logic [BW-1:0] blink_cnt;
  logic [DW-1:0] dur_cnt;
  logic          phase_q;
  logic          wrap;
  logic          adv;

  assign wrap = (blink_cnt == BLINK_LAST);
  assign done = (dur_cnt == DUR_LAST);
  assign adv  = enable & ~done;

  // phase is look-ahead: the value the banner should show after this edge,
  // so the registered display word toggles exactly every BLINK_CYC cycles
  always_comb begin
    phase = phase_q;
    if (restart)          phase = 1'b1;
    else if (adv && wrap) phase = ~phase_q;
  end

  // Duration and blink counters; restart rearms, they stop advancing once done
  always_ff @(posedge clk_16) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      dur_cnt   <= '0;
      phase_q   <= 1'b0;
    end else if (restart) begin
      blink_cnt <= '0;
      dur_cnt   <= '0;
      phase_q   <= 1'b1;
    end else if (adv) begin
      dur_cnt   <= dur_cnt + 1'b1;
      blink_cnt <= wrap ? '0 : blink_cnt + 1'b1;
      phase_q   <= phase_q ^ wrap;
    end
  end

endmodule

// File: rtl/wam_dis_sched.sv
// rtl/wam_dis_sched.sv - tube display scheduler (banner > timer > score); WAM_DIS_LZB_EN enables score leading-zero blanking
module wam_dis_sched
  import wam_dis_pkg::*;
#(
  parameter int HOLD_CYC   = 32,
  parameter int BLINK_CYC  = 8,
  parameter int BANNER_CYC = 64
) (
  input  logic        clk_16,
  input  logic        rst_n,
  input  logic [11:0] score,
  input  logic        tmr_req,
  input  logic [11:0] tmr_val,
  input  logic        ban_req,
  input  logic [15:0] ban_code,
  input  logic        freeze,
  output logic [15:0] disp,
  output logic [1:0]  src,
  output logic        busy
);

`ifdef WAM_DIS_LZB_EN
  localparam logic LZB = 1'b1;
`else
  localparam logic LZB = 1'b0;
`endif

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC);

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [11:0]   tmr_q;
  logic [15:0]   ban_code_q;
  logic          pend_q;
  logic [15:0]   pend_code_q;

  logic          ban_go;
  logic [15:0]   ban_word;
  logic [11:0]   tmr_word;
  logic          blink_en;
  logic          phase;
  logic          done;

  // A banner request seen now or parked during freeze; the live pulse carries the newest code
  assign ban_go   = ~freeze & (ban_req | pend_q);
  assign ban_word = ban_req ? ban_code : pend_code_q;
  assign tmr_word = tmr_req ? tmr_val : tmr_q;
  assign blink_en = ~freeze & (state == ST_BANNER);

  wam_dis_blink #(
    .BLINK_CYC  (BLINK_CYC),
    .BANNER_CYC (BANNER_CYC)
  ) u_blink (
    .clk_16  (clk_16),
    .rst_n   (rst_n),
    .restart (ban_go),
    .enable  (blink_en),
    .phase   (phase),
    .done    (done)
  );

  // Source arbitration FSM; disp/src/busy are registered from the next state
  always_ff @(posedge clk_16) begin
    if (!rst_n) begin
      state       <= ST_SCORE;
      hold_cnt    <= '0;
      tmr_q       <= '0;
      ban_code_q  <= '0;
      pend_q      <= 1'b0;
      pend_code_q <= '0;
      disp        <= WORD_BLANK;
      src         <= SRC_SCORE;
      busy        <= 1'b0;
    end else if (freeze) begin
      if (ban_req) begin
        pend_q      <= 1'b1;
        pend_code_q <= ban_code;
      end
    end else begin
      pend_q <= 1'b0;
      if (tmr_req) tmr_q <= tmr_val;
      if (ban_go) begin
        state      <= ST_BANNER;
        ban_code_q <= ban_word;
        disp       <= ban_word;
        src        <= SRC_BANNER;
        busy       <= 1'b1;
      end else begin
        case (state)
          ST_SCORE: begin
            if (tmr_req) begin
              state    <= ST_TIMER;
              hold_cnt <= '0;
              disp     <= {NIB_BLANK, tmr_val};
              src      <= SRC_TIMER;
              busy     <= 1'b1;
            end else begin
              disp <= score_word(score, LZB);
              src  <= SRC_SCORE;
              busy <= 1'b0;
            end
          end
          ST_TIMER: begin
            if (!tmr_req && (hold_cnt == HOLD_MAX)) begin
              state <= ST_SCORE;
              disp  <= score_word(score, LZB);
              src   <= SRC_SCORE;
              busy  <= 1'b0;
            end else begin
              if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
              disp <= {NIB_BLANK, tmr_word};
              src  <= SRC_TIMER;
              busy <= 1'b1;
            end
          end
          ST_BANNER: begin
            if (done) begin
              if (tmr_req) begin
                state    <= ST_TIMER;
                hold_cnt <= '0;
                disp     <= {NIB_BLANK, tmr_val};
                src      <= SRC_TIMER;
                busy     <= 1'b1;
              end else begin
                state <= ST_SCORE;
                disp  <= score_word(score, LZB);
                src   <= SRC_SCORE;
                busy  <= 1'b0;
              end
            end else begin
              disp <= phase ? ban_code_q : WORD_BLANK;
              src  <= SRC_BANNER;
              busy <= 1'b1;
            end
          end
          default: begin
            state <= ST_SCORE;
            disp  <= WORD_BLANK;
            src   <= SRC_SCORE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wam_dis_sched.sv
// tb/tb_wam_dis_sched.sv - self-checking bench for wam_dis_sched against a cycle-age reference model
module tb_wam_dis_sched;

  localparam int HOLD   = 32;
  localparam int BLINK  = 8;
  localparam int BANNER = 64;

  logic        clk_16 = 1'b0;
  logic        rst_n;
  logic [11:0] score;
  logic        tmr_req;
  logic [11:0] tmr_val;
  logic        ban_req;
  logic [15:0] ban_code;
  logic        freeze;
  logic [15:0] disp;
  logic [1:0]  src;
  logic        busy;

  always #5 clk_16 = ~clk_16;

  wam_dis_sched #(
    .HOLD_CYC   (HOLD),
    .BLINK_CYC  (BLINK),
    .BANNER_CYC (BANNER)
  ) dut (
    .clk_16   (clk_16),
    .rst_n    (rst_n),
    .score    (score),
    .tmr_req  (tmr_req),
    .tmr_val  (tmr_val),
    .ban_req  (ban_req),
    .ban_code (ban_code),
    .freeze   (freeze),
    .disp     (disp),
    .src      (src),
    .busy     (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 score, 1 timer, 2 banner; age = edges since mode entry
  int          m_mode;
  int          m_age;
  logic [15:0] m_code;
  logic [11:0] m_tval;
  bit          m_pend;
  logic [15:0] m_pcode;
  logic [15:0] m_disp;

  function automatic logic [15:0] exp_score(input logic [11:0] s);
    logic [3:0] h;
    logic [3:0] t;
    h = s[11:8];
    t = s[7:4];
`ifdef WAM_DIS_LZB_EN
    if (h == 0) begin
      h = 4'hA;
      if (t == 0) t = 4'hA;
    end
`endif
    return {4'hB, h, t, s[3:0]};
  endfunction

  task automatic enter_timer();
    m_mode = 1;
    m_age  = 0;
    m_disp = {4'hA, m_tval};
  endtask

  task automatic enter_score();
    m_mode = 0;
    m_age  = 0;
    m_disp = exp_score(score);
  endtask

  task automatic model_edge();
    bit          ban;
    logic [15:0] code;
    if (!rst_n) begin
      m_mode = 0; m_age = 0; m_code = '0; m_tval = '0;
      m_pend = 0; m_pcode = '0; m_disp = 16'hAAAA;
    end else if (freeze) begin
      if (ban_req) begin
        m_pend  = 1;
        m_pcode = ban_code;
      end
    end else begin
      ban    = ban_req || m_pend;
      code   = ban_req ? ban_code : m_pcode;
      m_pend = 0;
      if (tmr_req) m_tval = tmr_val;
      if (ban) begin
        m_mode = 2; m_age = 0; m_code = code; m_disp = code;
      end else if (m_mode == 0) begin
        if (tmr_req) enter_timer();
        else m_disp = exp_score(score);
      end else if (m_mode == 1) begin
        m_age++;
        if (!tmr_req && m_age > HOLD) enter_score();
        else m_disp = {4'hA, m_tval};
      end else begin
        m_age++;
        if (m_age == BANNER) begin
          if (tmr_req) enter_timer();
          else enter_score();
        end else begin
          m_disp = (((m_age / BLINK) % 2) == 0) ? m_code : 16'hAAAA;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk_16);
    model_edge();
    @(negedge clk_16);
    chk("disp", disp, m_disp);
    chk("src",  src,  m_mode);
    chk("busy", busy, m_mode != 0);
  endtask

  function automatic logic [11:0] rnd_bcd();
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  initial begin
    int n;
    rst_n = 0; score = 12'h042; tmr_req = 0; tmr_val = 0;
    ban_req = 0; ban_code = 0; freeze = 0;
    @(negedge clk_16);
    step();
    chk("reset_disp", disp, 16'hAAAA);
    chk("reset_src", src, 0);
    chk("reset_busy", busy, 0);
    step();
    rst_n = 1;
    repeat (3) step();
`ifdef WAM_DIS_LZB_EN
    chk("score_word", disp, 16'hBA42);
`else
    chk("score_word", disp, 16'hB042);
`endif

    // Timer entry, early release, hold to expiry
    tmr_req = 1; tmr_val = 12'h059;
    step();
    chk("timer_entry", disp, 16'hA059);
    chk("timer_src", src, 1);
    repeat (4) step();
    tmr_req = 0; tmr_val = 12'h777;
    n = 4;
    while (src == 1 && n < 100) begin
      step();
      n++;
    end
    chk("timer_exit_edge", n, HOLD + 1);

    // Banner from score with blink, then retrigger at cycle 30
    ban_req = 1; ban_code = 16'hB0E0;
    step();
    ban_req = 0;
    chk("banner_on", disp, 16'hB0E0);
    repeat (8) step();
    chk("banner_off", disp, 16'hAAAA);
    repeat (21) step();
    ban_req = 1; ban_code = 16'h1234;
    step();
    ban_req = 0;
    chk("retrig_code", disp, 16'h1234);
    repeat (63) step();
    chk("retrig_still", src, 2);
    step();
    chk("banner_done", src, 0);

    // Banner preempting a held timer returns to timer
    tmr_req = 1; tmr_val = 12'h321;
    repeat (3) step();
    ban_req = 1; ban_code = 16'h5555;
    step();
    ban_req = 0;
    chk("preempt", src, 2);
    repeat (64) step();
    chk("back_to_timer", src, 1);
    tmr_req = 0;
    repeat (HOLD + 2) step();
    chk("timer_after_ban", src, 0);

    // Freeze mid-banner with a pending pulse
    ban_req = 1; ban_code = 16'h9999;
    step();
    ban_req = 0;
    repeat (5) step();
    freeze = 1;
    repeat (3) step();
    ban_req = 1; ban_code = 16'h4321;
    step();
    ban_code = 16'h8765;
    step();
    ban_req = 0;
    repeat (5) step();
    freeze = 0;
    step();
    chk("pend_code", disp, 16'h8765);
    repeat (70) step();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst_n   = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 29) == 0) freeze = ~freeze;
      if ($urandom_range(0, 39) == 0) tmr_req = ~tmr_req;
      ban_req  = ($urandom_range(0, 99) < 2);
      ban_code = 16'($urandom);
      tmr_val  = rnd_bcd();
      if ($urandom_range(0, 3) == 0) score = rnd_bcd();
      if ($urandom_range(0, 9) == 0) score[11:4] = '0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
